// File: rtl/dbus_lsu_pkg.sv
// Shared memory-op and data-bus types plus the op decode helpers used by the LSU.
package common;

  typedef enum logic [3:0] {
    OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
    OP_SB, OP_SH, OP_SW, OP_SD
  } mem_op_t;

  typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} lsu_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  function automatic msize_t op_size(mem_op_t op);
    msize_t sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = MSIZE1;
      OP_LH, OP_LHU, OP_SH: sz = MSIZE2;
      OP_LW, OP_LWU, OP_SW: sz = MSIZE4;
      default:              sz = MSIZE8;
    endcase
    return sz;
  endfunction

  function automatic logic op_is_store(mem_op_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SD);
  endfunction

  function automatic logic op_is_signed(mem_op_t op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
  endfunction

  function automatic logic is_misaligned(msize_t sz, logic [2:0] a);
    logic m;
    case (sz)
      MSIZE1:  m = 1'b0;
      MSIZE2:  m = a[0];
      MSIZE4:  m = |a[1:0];
      default: m = |a[2:0];
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dbus_lsu_align.sv
// Combinational lane logic: store data/strobe shifted onto the 64-bit bus,
// load data shifted down, truncated to the access size and extended.
module lsu_align
  import common::*;
(
  input  mem_op_t     op,
  input  logic [2:0]  sh,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] st_data,
  output logic [7:0]  st_strobe,
  output logic [63:0] ld_data
);

  msize_t      sz;
  logic [7:0]  mask;
  logic [63:0] raw;
  logic        sgn;

  always_comb begin
    sz   = op_size(op);
    sgn  = op_is_signed(op);
    raw  = rdata >> {sh, 3'b000};
    mask = 8'h01;
    ld_data = raw;
    case (sz)
      MSIZE1: begin
        mask    = 8'h01;
        ld_data = {{56{sgn & raw[7]}}, raw[7:0]};
      end
      MSIZE2: begin
        mask    = 8'h03;
        ld_data = {{48{sgn & raw[15]}}, raw[15:0]};
      end
      MSIZE4: begin
        mask    = 8'h0F;
        ld_data = {{32{sgn & raw[31]}}, raw[31:0]};
      end
      default: begin
        mask    = 8'hFF;
        ld_data = raw;
      end
    endcase
    st_data   = wdata << {sh, 3'b000};
    st_strobe = op_is_store(op) ? (mask << sh) : 8'h00;
  end

endmodule

// File: rtl/dbus_lsu.sv
// Single-outstanding load/store unit in front of the data cache: holds dreq
// stable until data_ok, traps misaligned ops locally, returns extended load data.
module dbus_lsu
  import common::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  mem_op_t     in_op,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_misalign,
  output dbus_req_t   dreq,
  input  dbus_resp_t  dresp
);

  lsu_state_t  state, state_n;
  logic        live;
  mem_op_t     op_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [4:0]  rd_q;
  logic [63:0] out_data_q;
  logic [4:0]  out_rd_q;
  logic        out_mis_q;

  logic        accept;
  logic        in_mis;
  logic [63:0] st_data;
  logic [7:0]  st_strobe;
  logic [63:0] ld_data;
  logic        unused_addr_ok;

  assign unused_addr_ok = dresp.addr_ok;

  lsu_align u_align (
    .op        (op_q),
    .sh        (addr_q[2:0]),
    .wdata     (wdata_q),
    .rdata     (dresp.data),
    .st_data   (st_data),
    .st_strobe (st_strobe),
    .ld_data   (ld_data)
  );

  // live keeps in_ready low until the first clock edge after reset release
  assign in_ready  = live & ((state == S_IDLE) | ((state == S_RESP) & out_ready));
  assign accept    = in_valid & in_ready;
  assign in_mis    = CHECK_ALIGN & is_misaligned(op_size(in_op), in_addr[2:0]);
  assign out_valid = (state == S_RESP);
  assign out_data  = out_data_q;
  assign out_rd    = out_rd_q;
  assign out_misalign = out_mis_q;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = in_mis ? S_RESP : S_REQ;
      S_REQ:  if (dresp.data_ok) state_n = S_RESP;
      S_RESP: begin
        if (accept)         state_n = in_mis ? S_RESP : S_REQ;
        else if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    dreq = '0;
    if (state == S_REQ) begin
      dreq.valid  = 1'b1;
      dreq.addr   = addr_q;
      dreq.size   = op_size(op_q);
      dreq.strobe = st_strobe;
      dreq.data   = st_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      live       <= 1'b0;
      op_q       <= OP_LB;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      out_data_q <= '0;
      out_rd_q   <= '0;
      out_mis_q  <= 1'b0;
    end else begin
      state <= state_n;
      live  <= 1'b1;
      if (accept) begin
        op_q    <= in_op;
        addr_q  <= in_addr;
        wdata_q <= in_wdata;
        rd_q    <= in_rd;
        if (in_mis) begin
          out_data_q <= '0;
          out_rd_q   <= in_rd;
          out_mis_q  <= 1'b1;
        end
      end
      if ((state == S_REQ) && dresp.data_ok) begin
        out_data_q <= op_is_store(op_q) ? 64'd0 : ld_data;
        out_rd_q   <= rd_q;
        out_mis_q  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dbus_lsu.md
# dbus_lsu

Load/store unit that sits directly upstream of the data cache. It accepts one memory operation at a time from the memory pipeline stage and aligns store data and byte strobes onto the 64-bit data bus. It drives the data-bus request stable until the cache completes it, then returns sign- or zero-extended load results. Misaligned accesses are trapped locally and never reach the bus.

## Interface
Parameters:
- `CHECK_ALIGN`, default 1: when 1, misaligned accesses raise `out_misalign`; when 0, they are issued unchanged.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  operation accepted this cycle when `in_valid & in_ready`.
- `in_op`  in  `mem_op_t`  LB/LH/LW/LD/LBU/LHU/LWU/SB/SH/SW/SD.
- `in_addr`  in  64  byte address.
- `in_wdata`  in  64  store data, right-aligned.
- `in_rd`  in  5  destination tag, passed through.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  64  extended load result; 0 for stores.
- `out_rd`  out  5  tag of the completed operation.
- `out_misalign`  out  1  the operation trapped and performed no bus access.
- `dreq`  out  `dbus_req_t`  data-bus request (valid, addr, size, strobe, data).
- `dresp`  in  `dbus_resp_t`  data-bus response (addr_ok, data_ok, data).

## Operation
- **States:** IDLE, REQ, RESP.
- **Accept:** on an `in_valid & in_ready` handshake, latch op/addr/wdata/rd.
  - Misaligned (`addr % size != 0`, with `CHECK_ALIGN`=1): go to RESP with misalign=1.
  - Otherwise: go to REQ.
- **REQ:**
  - `dreq.valid` = 1 with latched fields.
  - Every `dreq` field is held constant until and including the cycle `dresp.data_ok` = 1. `addr_ok` alone does not release the request.
  - On `data_ok`: register the result and go to RESP.
- **RESP:**
  - `out_valid` = 1, held until `out_ready`.
  - `out_ready & in_valid` in RESP: accept the new op the same cycle (back-to-back) and go to REQ or RESP.
  - `out_ready` without `in_valid`: go to IDLE.
- **`in_ready`** = (state==IDLE) | (state==RESP & out_ready).
- **Size mapping:** B→MSIZE1, H→MSIZE2, W→MSIZE4, D→MSIZE8.
- **Store lane alignment:**
  - Let `sh = addr[2:0]`.
  - `dreq.data` = wdata << (8·sh).
  - `dreq.strobe` = mask << sh, with mask 0x01/0x03/0x0F/0xFF by size.
  - Loads use strobe 0.
- **Load extraction:**
  - Let `raw = dresp.data >> (8·sh)`.
  - Truncate `raw` to the access size.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD passes through.
- **`dreq.addr`:** the full latched address, no lane masking. The cache decides cached vs. uncached from `addr[31]`.
- **Reset (asserted at any time, including mid-REQ):**
  - State returns to IDLE immediately.
  - `dreq` = 0, `out_valid` = 0, `out_data` = 0, `out_rd` = 0, `out_misalign` = 0, `in_ready` = 0.
  - `in_ready` returns to 1 on the first clock after deassertion.
  - The cache is reset concurrently; an abandoned request is not replayed.

## Timing
- **Cache hit:** accept at cycle 0; `dreq.valid` from cycle 1; `data_ok` in cycle 1; `out_valid` in cycle 2. Load-to-use latency is 2 cycles.
- **Miss/uncached:** `out_valid` follows the `data_ok` cycle by exactly 1 cycle.
- **Misaligned:** `out_valid` at cycle 1; `dreq.valid` never asserted.
- **Drop of `dreq.valid`:** in the cycle after `data_ok`, `dreq.valid` deasserts, unless a back-to-back request was accepted in RESP. In that case the new request appears no earlier than 1 cycle after RESP, so at most one request is ever outstanding.
- **Output stability:** `out_*` is registered and stable while `out_valid & ~out_ready`.

## Structure
- **Shared package** (`common`): `mem_op_t` enum and the size/extend decode helper functions. `dbus_req_t`, `dbus_resp_t` and `msize_t` already live there.
- **Sub-module:** `lsu_align`, combinational, containing the store-lane shifter/strobe generator and the load extractor/extender. It is instantiated once and is unit-testable alone.
- **FSM and registers** stay in `dbus_lsu`.

## Test plan
- **SB:** SB addr 0x8000_0005, wdata 0xAB → `dreq.strobe`=0x20, `dreq.data`=0x0000_AB00_0000_0000, size MSIZE1.
- **LH sign-extend:** LH addr 0x8000_0002, `dresp.data`=0x0000_0000_8001_0000 with hit → `out_data`=0xFFFF_FFFF_FFFF_8001, `out_valid` 2 cycles after accept. LHU same → 0x8001.
- **Misaligned:** LW addr 0x8000_0006 → no `dreq.valid` ever, `out_misalign`=1 at cycle 1.
- **Miss stall:** LD addr 0x8000_0040, `data_ok` withheld 20 cycles while `addr_ok` toggles → `dreq` bit-stable all 20 cycles, `out_valid` the cycle after `data_ok`.
- **Back-to-back:** `out_ready`=1 and `in_valid`=1 in RESP → new op accepted that cycle, and two results are delivered without an IDLE cycle.
- **Reset mid-op:** `reset` pulled low mid-REQ → `dreq.valid` falls within the same cycle, all outputs 0, next op after release completes normally.
